phys_regfile: RTL

//  Physical register file: the responder to the issue stage's operand-read interface.
//  - Each cycle, issue drives two physical indices per FU (reg_idx_1/2).
//  - This block returns the operand values (reg_data_1/2) combinationally in the same cycle.
//  - The complete stage writes results through NUM_WR CDB write ports.
//  - Physical register 0 is hardwired to zero.

---
 rtl/phys_regfile_pkg.sv | 23 ++
 rtl/phys_regfile_rd_port.sv | 69 ++++++
 rtl/phys_regfile.sv | 109 ++++++++++
 3 files changed

// File: rtl/phys_regfile_pkg.sv
// Shared definitions for the physical register file.
//
// Holds the machine-wide sizes used by phys_regfile and its read-port
// sub-module: FU count, CDB width, physical register count, index and data
// widths, plus the matching data/index typedefs.
//
// Optional feature macro used by this codebase slice: REGFILE_BYPASS_EN
// (same-cycle write-to-read forwarding in the read ports).
package phys_regfile_pkg;

    // Read-port pairs, one per FU in order ALU, MULT, LD, ST, BR.
    localparam int NUM_FUS        = 5;
    // CDB width: number of write lanes.
    localparam int CDB_N          = 3;
    // Number of physical registers (entry 0 is the hardwired zero register).
    localparam int PHYS_REG_SZ    = 64;
    localparam int PHYS_REG_IDX_W = $clog2(PHYS_REG_SZ);
    localparam int DATA_W         = 32;

    typedef logic [DATA_W-1:0]         data_t;
    typedef logic [PHYS_REG_IDX_W-1:0] phys_reg_idx_t;

endpackage

// File: rtl/phys_regfile_rd_port.sv
// One combinational read port of the physical register file.
//
// Ports:
//   idx      in   IDX_W                  physical register to read
//   mem      in   PHYS_REGS x DATA_W     stored register image (entry 0 is zero)
//   wr_en    in   NUM_WR                 CDB write strobes (already gated by reset)
//   wr_idx   in   NUM_WR x IDX_W         CDB destination registers
//   wr_data  in   NUM_WR x DATA_W        CDB result values
//   data     out  DATA_W                 operand value
//
// Index 0 always returns zero. When REGFILE_BYPASS_EN is defined, a CDB lane
// writing the requested register in this same cycle is forwarded, highest
// lane winning; otherwise only the stored value is returned and the CDB
// inputs are unused.
module phys_regfile_rd_port
    import phys_regfile_pkg::*;
#(
    parameter int NUM_WR    = CDB_N,
    parameter int PHYS_REGS = PHYS_REG_SZ,
    parameter int IDX_W     = $clog2(PHYS_REGS),
    parameter int DW        = DATA_W
) (
    input  logic [IDX_W-1:0]                idx,
    input  logic [PHYS_REGS-1:0][DW-1:0]    mem,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR-1:0][IDX_W-1:0]    wr_idx,
    input  logic [NUM_WR-1:0][DW-1:0]       wr_data,
    output logic [DW-1:0]                   data
);

    logic [DW-1:0] stored_s;
    logic [DW-1:0] data_s;

    // Stored value with the zero-register check applied.
    always_comb begin
        stored_s = {DW{1'b0}};
        if (idx == {IDX_W{1'b0}}) begin
            stored_s = {DW{1'b0}};
        end else begin
            stored_s = mem[idx];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward a same-cycle CDB write; ascending scan so the highest lane wins.
    always_comb begin
        data_s = stored_s;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_idx[k] == idx) && (idx != {IDX_W{1'b0}})) begin
                data_s = wr_data[k];
            end else begin
                data_s = data_s;
            end
        end
    end
`else
    // CDB inputs only matter for forwarding; fold them away in this build.
    logic unused_s;
    assign unused_s = ^{wr_en, wr_idx, wr_data};

    // Without forwarding the port returns stored data only.
    always_comb begin
        data_s = stored_s;
    end
`endif

    assign data = data_s;

endmodule

// File: rtl/phys_regfile.sv
// Physical register file: operand-read responder for the issue stage.
//
// Ports:
//   clock      in   1                   system clock, rising edge
//   reset_n    in   1                   asynchronous active-low reset (clears all entries)
//   rd_idx_1   in   NUM_FU x IDX_W      operand-1 index per FU
//   rd_idx_2   in   NUM_FU x IDX_W      operand-2 index per FU
//   rd_data_1  out  NUM_FU x DATA_W     operand-1 value per FU (combinational)
//   rd_data_2  out  NUM_FU x DATA_W     operand-2 value per FU (combinational)
//   wr_en      in   NUM_WR              write strobe per CDB lane
//   wr_idx     in   NUM_WR x IDX_W      destination physical register per lane
//   wr_data    in   NUM_WR x DATA_W     result value per lane
//   dbg_idx    in   IDX_W               debug read index
//   dbg_data   out  DATA_W              stored value at dbg_idx, never forwarded
//
// Configuration macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on the operand ports. Physical register 0 is not stored and
// always reads zero. On a same-cycle write collision the highest lane wins.
module phys_regfile
    import phys_regfile_pkg::*;
#(
    parameter int NUM_FU    = NUM_FUS,
    parameter int NUM_WR    = CDB_N,
    parameter int PHYS_REGS = PHYS_REG_SZ,
    localparam int IDX_W    = $clog2(PHYS_REGS)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_FU-1:0][IDX_W-1:0]      rd_idx_1,
    input  logic [NUM_FU-1:0][IDX_W-1:0]      rd_idx_2,
    output logic [NUM_FU-1:0][DATA_W-1:0]     rd_data_1,
    output logic [NUM_FU-1:0][DATA_W-1:0]     rd_data_2,
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR-1:0][IDX_W-1:0]      wr_idx,
    input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data,
    input  logic [IDX_W-1:0]                  dbg_idx,
    output logic [DATA_W-1:0]                 dbg_data
);

    // Entries 1..PHYS_REGS-1 are real flops; entry 0 is a constant zero.
    logic [PHYS_REGS-1:1][DATA_W-1:0] mem_r;
    logic [PHYS_REGS-1:0][DATA_W-1:0] mem_s;
    // Write strobes as seen by the forwarding muxes: nothing is forwarded
    // while reset is asserted, so every port reads zero during reset.
    logic [NUM_WR-1:0]                wr_en_s;

    assign mem_s   = {mem_r, {DATA_W{1'b0}}};
    assign wr_en_s = reset_n ? wr_en : {NUM_WR{1'b0}};

    // Storage update: ascending lane order so the highest lane wins a collision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_r <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_idx[k] != {IDX_W{1'b0}})) begin
                    mem_r[wr_idx[k]] <= wr_data[k];
                end
            end
        end
    end

    // Two operand read ports per FU.
    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        phys_regfile_rd_port #(
            .NUM_WR    (NUM_WR),
            .PHYS_REGS (PHYS_REGS),
            .IDX_W     (IDX_W),
            .DW        (DATA_W)
        ) u_rd_1 (
            .idx     (rd_idx_1[f]),
            .mem     (mem_s),
            .wr_en   (wr_en_s),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .data    (rd_data_1[f])
        );

        phys_regfile_rd_port #(
            .NUM_WR    (NUM_WR),
            .PHYS_REGS (PHYS_REGS),
            .IDX_W     (IDX_W),
            .DW        (DATA_W)
        ) u_rd_2 (
            .idx     (rd_idx_2[f]),
            .mem     (mem_s),
            .wr_en   (wr_en_s),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .data    (rd_data_2[f])
        );
    end

    // Debug port: strobes tied off so it always shows stored state.
    phys_regfile_rd_port #(
        .NUM_WR    (NUM_WR),
        .PHYS_REGS (PHYS_REGS),
        .IDX_W     (IDX_W),
        .DW        (DATA_W)
    ) u_rd_dbg (
        .idx     (dbg_idx),
        .mem     (mem_s),
        .wr_en   ({NUM_WR{1'b0}}),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .data    (dbg_data)
    );

endmodule
